seq_fetch_ctrl: RTL and testbench
=================================

# seq_fetch_ctrl

Control stage directly upstream of the 8-bit loadable address counter (`count8a`) in the memory unit. It drives that counter's `EN`, `load` and `CNT_In` inputs to walk an address window `start_addr..end_addr` one address per accepted fetch beat. It handles the valid/ready handshake with the memory consumer, redirects the counter on jump requests, and counts accepted beats.

## Interface

Parameters
- `ADDR_W`, 8: address width; must equal the counter width.

Ports
- `clk`  in  1: single clock, rising edge; shared with the counter.
- `res`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a walk; sampled only in IDLE.
- `start_addr`  in  ADDR_W: first address of the walk.
- `end_addr`  in  ADDR_W: last address; latched on `start`.
- `jmp_req`  in  1: redirect the counter on the current accepted beat.
- `jmp_addr`  in  ADDR_W: jump target.
- `abort`  in  1: terminate the walk immediately.
- `cnt`  in  ADDR_W: counter output (current address), fed back.
- `fetch_ready`  in  1: consumer accepts the current address.
- `fetch_valid`  out  1: `cnt` is a valid fetch address this cycle.
- `cnt_en`  out  1: to counter `EN`.
- `cnt_load`  out  1: to counter `load`.
- `cnt_in`  out  ADDR_W: to counter `CNT_In`.
- `busy`  out  1: state is RUN.
- `done`  out  1: one-cycle pulse at end of walk.
- `beats`  out  ADDR_W+1: accepted-beat count of the current or last walk.

## Operation

- States: IDLE, RUN, DONE.
- `cnt_en` and `cnt_load` are never high in the same cycle. The counter gives `load` priority, so any overlap is a design error.
- `cnt_in` is 0 whenever `cnt_load` is 0.
- IDLE: `fetch_valid=0`, `busy=0`.
  - On `start`: `cnt_load=1`, `cnt_in=start_addr`, latch `end_addr`, clear `beats`, go to RUN.
- RUN: `fetch_valid=1`, `busy=1`. A beat is accepted when `fetch_valid & fetch_ready`. Priority, highest first:
  - `abort`: go to IDLE, no load, no enable, beat not counted, no `done`.
  - Accepted beat with `jmp_req`: `beats+1`, `cnt_load=1`, `cnt_in=jmp_addr`, stay in RUN. A jump overrides the end check, even when `cnt==end_addr`.
  - Accepted beat with `cnt==end_addr_q`: `beats+1`, go to DONE, counter holds.
  - Accepted beat otherwise: `beats+1`, `cnt_en=1`.
  - No accept: hold, `cnt_en=cnt_load=0`. `jmp_req` is ignored.
- DONE: `done=1` for exactly one cycle, `fetch_valid=0`, then go to IDLE.
  - `start` in DONE is ignored.
- `start` in RUN or DONE is ignored.
- Wrap-around: if `end_addr < start_addr`, the counter wraps 255→0 and the walk continues to `end_addr`. Maximum walk length is 256 beats, so `beats` is 9 bits and never saturates.
- `beats` holds its value in IDLE until the next `start`.

## Timing

- Reset: state IDLE; `fetch_valid=cnt_en=cnt_load=busy=done=0`; `cnt_in=0`; `beats=0`; latched end address 0.
- `res` asserted mid-walk returns to IDLE on the next edge with no `done`. The counter resets on the same `res`.
- All control outputs are combinational from state plus inputs. State, `beats` and the latched end address are registered.
- `start` sampled at edge k: counter holds `start_addr` after edge k, and `fetch_valid` is high in the cycle after edge k.
- Throughput: one address per cycle while `fetch_ready` stays high.
- Final beat accepted at edge m: `done` is high in cycle m+1, and state is IDLE after edge m+1.
- Latency from a jump accepted at edge j: `cnt==jmp_addr` after edge j.

## Structure

- Shared package:
  - state encoding constants, 2 bits: IDLE=00, RUN=01, DONE=10;
  - `ADDR_W` constant.
- One natural sub-module, `beat_counter`: 9-bit counter with synchronous clear and increment enable.
- The FSM and priority logic stay in the top.
- The bench instantiates `seq_fetch_ctrl` together with the address counter, closing the `cnt` loop.

## Test plan

- Reset, then idle: all outputs 0, `beats=0`.
- `start_addr=0x10`, `end_addr=0x13`, `fetch_ready=1`:
  - addresses 0x10, 0x11, 0x12, 0x13 on four consecutive cycles;
  - `done` pulses one cycle later;
  - `beats=4`.
- Same walk with `fetch_ready` low on alternate cycles: each address is held until accepted; `beats=4`; `cnt_en` only on accept cycles.
- `start_addr=0xFE`, `end_addr=0x01`: addresses 0xFE, 0xFF, 0x00, 0x01; `beats=4`.
- Window 0x20..0x2F with `jmp_req`, `jmp_addr=0x2C` on the beat at 0x22:
  - addresses are 0x20, 0x21, 0x22, 0x2C..0x2F;
  - `beats=7`;
  - `jmp_req` raised while `fetch_ready=0` has no effect.
- Mid-walk events:
  - `abort` at address 0x05: IDLE next cycle, no `done`, `beats` frozen.
  - Repeat with `res` instead: all outputs and `beats` are 0.

Source files
------------

// File: rtl/seq_fetch_ctrl_pkg.sv
// Shared types and constants for the sequential fetch controller.
package seq_fetch_ctrl_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned BEAT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/seq_fetch_ctrl_if.sv
// Control/handshake bundle between the fetch controller, its address counter and the consumer.
interface seq_fetch_ctrl_if
   import seq_fetch_ctrl_pkg::*;
;

   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic              jmp_req;
   logic [ADDR_W-1:0] jmp_addr;
   logic              abort;
   logic [ADDR_W-1:0] cnt;
   logic              fetch_ready;
   logic              fetch_valid;
   logic              cnt_en;
   logic              cnt_load;
   logic [ADDR_W-1:0] cnt_in;
   logic              busy;
   logic              done;
   logic [BEAT_W-1:0] beats;

   modport master (
      input  start, start_addr, end_addr, jmp_req, jmp_addr, abort, cnt, fetch_ready,
      output fetch_valid, cnt_en, cnt_load, cnt_in, busy, done, beats
   );

   modport slave (
      output start, start_addr, end_addr, jmp_req, jmp_addr, abort, cnt, fetch_ready,
      input  fetch_valid, cnt_en, cnt_load, cnt_in, busy, done, beats
   );

endinterface

// File: rtl/seq_fetch_ctrl_beat_counter.sv
// Accepted-beat counter: synchronous clear has priority over increment.
module beat_counter
   import seq_fetch_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = BEAT_W
) (
   input  logic             i_clk,
   input  logic             i_res,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_res || i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/seq_fetch_ctrl.sv
// Walks an external loadable address counter across start..end, one address per accepted beat,
// with jump redirect, abort and beat counting.
module seq_fetch_ctrl
   import seq_fetch_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_res,
   seq_fetch_ctrl_if.master io_bus
);

   state_e            r_state;
   state_e            w_state_next;
   logic [ADDR_W-1:0] r_end_addr;

   logic              w_fetch_valid;
   logic              w_cnt_en;
   logic              w_cnt_load;
   logic [ADDR_W-1:0] w_cnt_in;
   logic              w_busy;
   logic              w_done;
   logic              w_clr;
   logic              w_inc;
   logic              w_latch;
   logic [BEAT_W-1:0] w_beats;

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_state    <= ST_IDLE;
         r_end_addr <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_latch) begin
            r_end_addr <= io_bus.end_addr;
         end
      end
   end

   // In RUN fetch_valid is always high, so fetch_ready alone marks an accepted beat.
   always_comb begin
      w_state_next  = r_state;
      w_fetch_valid = 1'b0;
      w_cnt_en      = 1'b0;
      w_cnt_load    = 1'b0;
      w_cnt_in      = '0;
      w_busy        = 1'b0;
      w_done        = 1'b0;
      w_clr         = 1'b0;
      w_inc         = 1'b0;
      w_latch       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.start) begin
               w_cnt_load   = 1'b1;
               w_cnt_in     = io_bus.start_addr;
               w_latch      = 1'b1;
               w_clr        = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_fetch_valid = 1'b1;
            w_busy        = 1'b1;
            if (io_bus.abort) begin
               w_state_next = ST_IDLE;
            end else if (io_bus.fetch_ready) begin
               w_inc = 1'b1;
               if (io_bus.jmp_req) begin
                  w_cnt_load = 1'b1;
                  w_cnt_in   = io_bus.jmp_addr;
               end else if (io_bus.cnt == r_end_addr) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   beat_counter #(
      .WIDTH (BEAT_W)
   ) u_beat_counter (
      .i_clk   (i_clk),
      .i_res   (i_res),
      .i_clr   (w_clr),
      .i_inc   (w_inc),
      .o_count (w_beats)
   );

   assign io_bus.fetch_valid = w_fetch_valid;
   assign io_bus.cnt_en      = w_cnt_en;
   assign io_bus.cnt_load    = w_cnt_load;
   assign io_bus.cnt_in      = w_cnt_in;
   assign io_bus.busy        = w_busy;
   assign io_bus.done        = w_done;
   assign io_bus.beats       = w_beats;

endmodule

// File: tb/tb_seq_fetch_ctrl.sv
// Scoreboard bench: fetch controller closed around a loadable address counter model.
module tb_seq_fetch_ctrl;
   import seq_fetch_ctrl_pkg::*;

   typedef struct packed {
      logic       is_res;
      logic       done_exp;
      logic [8:0] beats;
   } end_t;

   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   seq_fetch_ctrl_if u_if ();

   seq_fetch_ctrl u_dut (
      .i_clk  (clk),
      .i_res  (res),
      .io_bus (u_if)
   );

   // Address counter: load has priority over enable.
   always @(posedge clk) begin
      if (res) u_if.cnt <= '0;
      else if (u_if.cnt_load) u_if.cnt <= u_if.cnt_in;
      else if (u_if.cnt_en) u_if.cnt <= u_if.cnt + 8'd1;
   end

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_addr_q[$];
   end_t       exp_end_q[$];
   bit         mon_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT shows an accepted beat or a walk ending.
   bit         pend = 1'b0;
   end_t       me;
   logic [7:0] ma;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("en_load_overlap", 32'(u_if.cnt_en & u_if.cnt_load), 0);
            if (!u_if.cnt_load) check("cnt_in_zero", 32'(u_if.cnt_in), 0);
            if (u_if.cnt_en) check("en_on_accept", 32'(u_if.fetch_valid & u_if.fetch_ready), 1);
            if (pend) begin
               pend = 1'b0;
               check("end_expected", 32'(exp_end_q.size() != 0), 1);
               if (exp_end_q.size() != 0) begin
                  me = exp_end_q.pop_front();
                  check("term_no_done", 32'(u_if.done), 0);
                  check("term_busy", 32'(u_if.busy), 0);
                  check("term_valid", 32'(u_if.fetch_valid), 0);
                  check("term_beats", 32'(u_if.beats), 32'(me.beats));
                  check("term_kind", 32'(me.done_exp), 0);
                  if (me.is_res) check("res_cnt", 32'(u_if.cnt), 0);
               end
            end else if ((res || u_if.abort) && u_if.busy) begin
               pend = 1'b1;
            end else if (u_if.done) begin
               check("end_expected", 32'(exp_end_q.size() != 0), 1);
               if (exp_end_q.size() != 0) begin
                  me = exp_end_q.pop_front();
                  check("done_expected", 32'(me.done_exp), 1);
                  check("done_beats", 32'(u_if.beats), 32'(me.beats));
                  check("done_valid", 32'(u_if.fetch_valid), 0);
               end
            end else if (u_if.fetch_valid && u_if.fetch_ready) begin
               check("beat_expected", 32'(exp_addr_q.size() != 0), 1);
               if (exp_addr_q.size() != 0) begin
                  ma = exp_addr_q.pop_front();
                  check("fetch_addr", 32'(u_if.cnt), 32'(ma));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One walk: reference address list from the window rules, then drive and push expectations.
   task automatic walk(input logic [7:0] s, input logic [7:0] e, input int jidx,
                       input logic [7:0] jt, input int cut_in, input bit use_res, input int rmode);
      logic [7:0] full[$];
      logic [7:0] a;
      int         n;
      int         cut;
      int         idx;
      int         budget;
      bit         rdy;
      bit         tog;
      end_t       ent;
      a   = s;
      cut = cut_in;
      forever begin
         full.push_back(a);
         if (full.size() - 1 == jidx) a = jt;
         else if (a == e) break;
         else a = a + 8'd1;
      end
      n = full.size();
      if (cut >= n) cut = -1;
      if (cut >= 0) begin
         for (int i = 0; i < cut; i++) exp_addr_q.push_back(full[i]);
         ent.is_res   = use_res;
         ent.done_exp = 1'b0;
         ent.beats    = use_res ? 9'd0 : 9'(cut);
      end else begin
         foreach (full[i]) exp_addr_q.push_back(full[i]);
         ent.is_res   = 1'b0;
         ent.done_exp = 1'b1;
         ent.beats    = 9'(n);
      end
      exp_end_q.push_back(ent);

      u_if.start      = 1'b1;
      u_if.start_addr = s;
      u_if.end_addr   = e;
      u_if.abort      = 1'b0;
      u_if.jmp_req    = 1'($urandom);
      u_if.jmp_addr   = 8'($urandom);
      tick();
      idx    = 0;
      budget = 4000;
      tog    = 1'b0;
      while (1) begin
         // start while busy must be ignored
         u_if.start      = ($urandom_range(0, 3) == 0);
         u_if.start_addr = 8'($urandom);
         u_if.end_addr   = 8'($urandom);
         if (idx == cut) begin
            if (use_res) res = 1'b1;
            else u_if.abort = 1'b1;
            u_if.fetch_ready = 1'($urandom);
            tick();
            res        = 1'b0;
            u_if.abort = 1'b0;
            u_if.start = 1'b0;
            break;
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = tog;
            default: rdy = 1'($urandom);
         endcase
         tog = ~tog;
         u_if.fetch_ready = rdy;
         if (rdy) begin
            u_if.jmp_req  = (idx == jidx);
            u_if.jmp_addr = (idx == jidx) ? jt : 8'($urandom);
         end else begin
            u_if.jmp_req  = 1'($urandom);
            u_if.jmp_addr = 8'($urandom);
         end
         tick();
         if (rdy) begin
            idx++;
            if (idx == n) break;
         end
         budget--;
         if (budget == 0) begin
            check("walk_budget", 0, 1);
            break;
         end
      end
      u_if.jmp_req = 1'b0;
      if (cut < 0) begin
         u_if.start       = 1'($urandom);
         u_if.fetch_ready = 1'($urandom);
         tick();
      end
      u_if.start = 1'b0;
      repeat (2) begin
         u_if.fetch_ready = 1'($urandom);
         u_if.jmp_req     = 1'($urandom);
         tick();
      end
      u_if.jmp_req = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] s;
      logic [7:0] e;
      logic [7:0] jt;
      int         len;
      int         jidx;
      int         cut;
      res              = 1'b1;
      u_if.start       = 1'b0;
      u_if.start_addr  = '0;
      u_if.end_addr    = '0;
      u_if.jmp_req     = 1'b0;
      u_if.jmp_addr    = '0;
      u_if.abort       = 1'b0;
      u_if.fetch_ready = 1'b0;
      repeat (3) tick();
      res = 1'b0;
      tick();
      check("rst_valid", 32'(u_if.fetch_valid), 0);
      check("rst_en", 32'(u_if.cnt_en), 0);
      check("rst_load", 32'(u_if.cnt_load), 0);
      check("rst_busy", 32'(u_if.busy), 0);
      check("rst_done", 32'(u_if.done), 0);
      check("rst_cnt_in", 32'(u_if.cnt_in), 0);
      check("rst_beats", 32'(u_if.beats), 0);
      check("rst_cnt", 32'(u_if.cnt), 0);
      mon_on = 1'b1;

      walk(8'h10, 8'h13, -1, 8'h00, -1, 1'b0, 0);
      walk(8'h10, 8'h13, -1, 8'h00, -1, 1'b0, 1);
      walk(8'hFE, 8'h01, -1, 8'h00, -1, 1'b0, 2);
      walk(8'h20, 8'h2F, 2, 8'h2C, -1, 1'b0, 2);
      walk(8'h00, 8'h0F, -1, 8'h00, 5, 1'b0, 2);
      walk(8'h00, 8'h0F, -1, 8'h00, 5, 1'b1, 2);
      walk(8'h30, 8'h30, 0, 8'h30, -1, 1'b0, 2);
      walk(8'h80, 8'h7F, -1, 8'h00, -1, 1'b0, 0);

      for (int k = 0; k < 25; k++) begin
         s    = 8'($urandom);
         len  = $urandom_range(0, 40);
         e    = s + 8'(len);
         jidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
         jt   = s + 8'($urandom_range(0, len));
         cut  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         walk(s, e, jidx, jt, cut, 1'($urandom), 2);
      end

      repeat (3) tick();
      check("addr_queue_drained", 32'(exp_addr_q.size()), 0);
      check("end_queue_drained", 32'(exp_end_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
